// File: rtl/host_pkg.sv
// host_pkg -- shared definitions for the host byte-stream framing.
//   Frame layout offsets, the demux FIFO entry layout, the "length 0 means
//   256" constant and the parser state encoding (shared with reg_manager).
//   No ports.
package host_pkg;

    // Byte offsets of the header fields within a frame
    localparam int unsigned OFS_DEST    = 0;
    localparam int unsigned OFS_LEN     = 1;
    localparam int unsigned OFS_PAYLOAD = 2;

    // A length byte of zero encodes a 256-byte payload
    localparam int unsigned LEN_ZERO_MEANS = 256;

    // Destination field width inside a FIFO entry (up to 8 sinks)
    localparam int unsigned DEST_W = 3;

    typedef struct packed {
        logic [7:0]        data;
        logic [DEST_W-1:0] dest;
        logic              sof;
        logic              eof;
    } fifo_entry_t;

    // Parser state encoding
    localparam logic [1:0] ST_DEST    = 2'd0;
    localparam logic [1:0] ST_LEN     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

endpackage

// File: rtl/in_demux_if.sv
// in_demux_if -- downstream byte-sink bus of in_demux.
//   imux_data_o  : payload byte at the FIFO head
//   imux_valid_o : one-hot valid, one bit per sink
//   imux_ready_i : per-sink accept
//   imux_sof_o   : head byte is first payload byte of its frame
//   imux_eof_o   : head byte is last payload byte of its frame
//   Modports: master (demux side), slave (sink side).
interface in_demux_if #(
    parameter int unsigned N_SINKS = 2
);
    logic [7:0]         imux_data_o;
    logic [N_SINKS-1:0] imux_valid_o;
    logic [N_SINKS-1:0] imux_ready_i;
    logic               imux_sof_o;
    logic               imux_eof_o;

    modport master (
        output imux_data_o, imux_valid_o, imux_sof_o, imux_eof_o,
        input  imux_ready_i
    );

    modport slave (
        input  imux_data_o, imux_valid_o, imux_sof_o, imux_eof_o,
        output imux_ready_i
    );
endinterface

// File: rtl/byte_fifo.sv
// byte_fifo -- synchronous FIFO with registered full/empty flags.
//   clk_i, nreset_i : clock, asynchronous active-low reset
//   i_wr_en/i_wr_data : push request (ignored while o_full)
//   i_rd_en           : pop request (ignored while o_empty)
//   o_rd_data         : head entry (combinational read of memory)
//   o_full/o_empty    : registered occupancy flags
// Pointers carry one extra wrap bit, so they run modulo 2*DEPTH and
// occupancy is simply their difference.
module byte_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             nreset_i,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             r_full;
    logic             r_empty;

    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_wptr_nxt;
    logic [AW:0]      w_rptr_nxt;
    logic [AW:0]      w_occ_nxt;

    // Refusal is decided on the registered flag, so a same-cycle pop never
    // makes room for a push into a full FIFO.
    assign w_push     = i_wr_en && !r_full;
    assign w_pop      = i_rd_en && !r_empty;
    assign w_wptr_nxt = r_wptr + {{AW{1'b0}}, w_push};
    assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_pop};
    assign w_occ_nxt  = w_wptr_nxt - w_rptr_nxt;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_full  <= (w_occ_nxt == OCC_FULL);
            r_empty <= (w_occ_nxt == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[r_rptr[AW-1:0]];
    assign o_full    = r_full;
    assign o_empty   = r_empty;
endmodule

// File: rtl/in_demux.sv
// in_demux -- parses host frames {dest, len, payload...} and routes the
// payload bytes through a FIFO to one of N_SINKS byte sinks.
//   clk_i          : system clock (rising edge)
//   nreset_i       : asynchronous active-low reset
//   in_data_i      : host byte
//   in_rdy_i       : one-cycle strobe qualifying in_data_i (no backpressure)
//   overflow_clr_i : synchronous clear of overflow_o (a new overflow wins)
//   overflow_o     : sticky, payload byte dropped on full FIFO
//   bad_dest_o     : one-cycle pulse, header named a non-existent sink
//   imux           : in_demux_if.master sink bus (data/valid/ready/sof/eof)
// Optional feature: define IN_DEMUX_TIMEOUT_EN to abandon a frame after
// TIMEOUT idle clocks inside it.
module in_demux
    import host_pkg::*;
#(
    parameter int unsigned N_SINKS    = 2,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic       clk_i,
    input  logic       nreset_i,
    input  logic [7:0] in_data_i,
    input  logic       in_rdy_i,
    input  logic       overflow_clr_i,
    output logic       overflow_o,
    output logic       bad_dest_o,
    in_demux_if.master imux
);
    logic [1:0]  r_state;
    logic [7:0]  r_dest;
    logic [8:0]  r_cnt;
    logic        r_first;
    logic        r_ovf;
    logic        r_bad_dest;

    logic        w_dest_ok;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_refused;
    logic        w_timeout;
    fifo_entry_t w_wr_entry;
    fifo_entry_t w_rd_entry;

    assign w_dest_ok = (r_dest < 8'(N_SINKS));
    assign w_push    = in_rdy_i && (r_state == ST_PAYLOAD);
    assign w_refused = w_push && w_full;
    assign w_pop     = |(imux.imux_valid_o & imux.imux_ready_i);

    always_comb begin
        w_wr_entry      = '0;
        w_wr_entry.data = in_data_i;
        w_wr_entry.dest = r_dest[DEST_W-1:0];
        w_wr_entry.sof  = r_first;
        w_wr_entry.eof  = (r_cnt == 9'd1);
    end

    byte_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .nreset_i  (nreset_i),
        .i_wr_en   (w_push),
        .i_wr_data (w_wr_entry),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_entry),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Outputs are forced to zero while empty so reset presents all-zero
    // head fields regardless of stale memory contents.
    always_comb begin
        imux.imux_valid_o = '0;
        for (int unsigned k = 0; k < N_SINKS; k++) begin
            imux.imux_valid_o[k] = !w_empty && (w_rd_entry.dest == DEST_W'(k));
        end
        imux.imux_data_o = w_empty ? 8'h00 : w_rd_entry.data;
        imux.imux_sof_o  = !w_empty && w_rd_entry.sof;
        imux.imux_eof_o  = !w_empty && w_rd_entry.eof;
    end

`ifdef IN_DEMUX_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] r_idle;

    assign w_timeout = (r_state != ST_DEST) && !in_rdy_i
                       && (r_idle == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_idle <= '0;
        end else if ((r_state == ST_DEST) || in_rdy_i || w_timeout) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_state    <= ST_DEST;
            r_dest     <= '0;
            r_cnt      <= '0;
            r_first    <= 1'b0;
            r_ovf      <= 1'b0;
            r_bad_dest <= 1'b0;
        end else begin
            r_bad_dest <= 1'b0;

            if (w_refused) begin
                r_ovf <= 1'b1;
            end else if (overflow_clr_i) begin
                r_ovf <= 1'b0;
            end

            case (r_state)
                ST_DEST: begin
                    if (in_rdy_i) begin
                        r_dest  <= in_data_i;
                        r_state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (in_rdy_i) begin
                        r_cnt   <= (in_data_i == 8'h00) ? 9'(LEN_ZERO_MEANS)
                                                        : {1'b0, in_data_i};
                        r_first <= 1'b1;
                        if (w_dest_ok) begin
                            r_state <= ST_PAYLOAD;
                        end else begin
                            r_state    <= ST_DISCARD;
                            r_bad_dest <= 1'b1;
                        end
                    end
                end
                ST_PAYLOAD, ST_DISCARD: begin
                    if (in_rdy_i) begin
                        r_first <= 1'b0;
                        if (r_cnt != 9'd0) begin
                            r_cnt <= r_cnt - 9'd1;
                        end
                        if (r_cnt <= 9'd1) begin
                            r_state <= ST_DEST;
                        end
                    end
                end
                default: r_state <= ST_DEST;
            endcase

            if (w_timeout) begin
                r_state <= ST_DEST;
                r_cnt   <= '0;
                r_first <= 1'b0;
            end
        end
    end

    assign overflow_o = r_ovf;
    assign bad_dest_o = r_bad_dest;
endmodule

// File: tb/tb_in_demux.sv
// tb_in_demux -- directed self-checking bench for in_demux (N_SINKS=2,
// FIFO_DEPTH=8, TIMEOUT=16). The timeout scenario runs only when
// IN_DEMUX_TIMEOUT_EN is defined.
module tb_in_demux;

    logic       clk;
    logic       nreset;
    logic [7:0] in_data;
    logic       in_rdy;
    logic       ovf_clr;
    logic       ovf;
    logic       bad_dest;

    int n_total;
    int n_bad;

    in_demux_if #(.N_SINKS(2)) u_if ();

    in_demux #(
        .N_SINKS    (2),
        .FIFO_DEPTH (8),
        .TIMEOUT    (16)
    ) u_dut (
        .clk_i          (clk),
        .nreset_i       (nreset),
        .in_data_i      (in_data),
        .in_rdy_i       (in_rdy),
        .overflow_clr_i (ovf_clr),
        .overflow_o     (ovf),
        .bad_dest_o     (bad_dest),
        .imux           (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All stimulus lives at posedge+1; each call advances exactly one edge.
    task automatic strobe(input logic [7:0] b);
        in_data = b;
        in_rdy  = 1'b1;
        @(posedge clk);
        #1;
        in_rdy  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [1:0] v, input logic [7:0] d,
                              input logic s, input logic e);
        check_eq({tag, ".valid"}, 32'(u_if.imux_valid_o), 32'(v));
        check_eq({tag, ".data"},  32'(u_if.imux_data_o),  32'(d));
        check_eq({tag, ".sof"},   32'(u_if.imux_sof_o),   32'(s));
        check_eq({tag, ".eof"},   32'(u_if.imux_eof_o),   32'(e));
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        nreset  = 1'b0;
        in_data = 8'h00;
        in_rdy  = 1'b0;
        ovf_clr = 1'b0;
        u_if.imux_ready_i = 2'b00;

        // Reset state
        tick();
        tick();
        check_head("rst", 2'b00, 8'h00, 1'b0, 1'b0);
        check_eq("rst.ovf", 32'(ovf), 32'd0);
        check_eq("rst.bad", 32'(bad_dest), 32'd0);
        nreset = 1'b1;
        tick();

        // Frame 00 03 AA BB CC, sink 0 always ready
        u_if.imux_ready_i = 2'b01;
        strobe(8'h00);
        strobe(8'h03);
        strobe(8'hAA);
        check_head("f1.aa", 2'b01, 8'hAA, 1'b1, 1'b0);
        strobe(8'hBB);
        check_head("f1.bb", 2'b01, 8'hBB, 1'b0, 1'b0);
        strobe(8'hCC);
        check_head("f1.cc", 2'b01, 8'hCC, 1'b0, 1'b1);
        tick();
        check_eq("f1.drained", 32'(u_if.imux_valid_o), 32'd0);

        // Bad destination 05, then 01 01 77 to sink 1
        u_if.imux_ready_i = 2'b11;
        strobe(8'h05);
        strobe(8'h02);
        check_eq("bd.pulse", 32'(bad_dest), 32'd1);
        strobe(8'h11);
        check_eq("bd.once", 32'(bad_dest), 32'd0);
        check_eq("bd.noval1", 32'(u_if.imux_valid_o), 32'd0);
        strobe(8'h22);
        check_eq("bd.noval2", 32'(u_if.imux_valid_o), 32'd0);
        u_if.imux_ready_i = 2'b00;
        strobe(8'h01);
        strobe(8'h01);
        strobe(8'h77);
        check_eq("bd.nopulse", 32'(bad_dest), 32'd0);
        check_head("bd.77", 2'b10, 8'h77, 1'b1, 1'b1);
        u_if.imux_ready_i = 2'b10;
        tick();
        check_eq("bd.drained", 32'(u_if.imux_valid_o), 32'd0);

        // Overflow: sink 0 stalled, 11-byte frame into an 8-deep FIFO
        u_if.imux_ready_i = 2'b00;
        strobe(8'h00);
        strobe(8'h0B);
        for (int i = 0; i < 8; i++) strobe(8'(8'h30 + i));
        check_eq("ov.none", 32'(ovf), 32'd0);
        strobe(8'h38);
        check_eq("ov.set", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_eq("ov.clr", 32'(ovf), 32'd0);
        strobe(8'h39);
        check_eq("ov.reset", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        strobe(8'h3A);
        ovf_clr = 1'b0;
        check_eq("ov.setwins", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_eq("ov.clr2", 32'(ovf), 32'd0);
        u_if.imux_ready_i = 2'b01;
        for (int i = 0; i < 8; i++) begin
            check_head($sformatf("ov.q%0d", i), 2'b01, 8'(8'h30 + i), (i == 0), 1'b0);
            tick();
        end
        check_eq("ov.drained", 32'(u_if.imux_valid_o), 32'd0);

        // 256-byte frame (length byte 00) to sink 1
        u_if.imux_ready_i = 2'b10;
        strobe(8'h01);
        strobe(8'h00);
        for (int i = 0; i < 256; i++) begin
            strobe(8'(i));
            check_eq($sformatf("l256.d%0d", i), 32'(u_if.imux_data_o), 32'(i[7:0]));
            check_eq($sformatf("l256.e%0d", i), 32'(u_if.imux_eof_o), 32'(i == 255));
            if (i == 0) check_eq("l256.sof", 32'(u_if.imux_sof_o), 32'd1);
        end
        check_eq("l256.valid", 32'(u_if.imux_valid_o), 32'b10);
        tick();
        check_eq("l256.drained", 32'(u_if.imux_valid_o), 32'd0);
        u_if.imux_ready_i = 2'b00;
        strobe(8'h00);
        strobe(8'h01);
        strobe(8'h5A);
        check_head("l256.next", 2'b01, 8'h5A, 1'b1, 1'b1);
        u_if.imux_ready_i = 2'b01;
        tick();

        // Reset in the middle of a frame
        u_if.imux_ready_i = 2'b00;
        strobe(8'h00);
        strobe(8'h04);
        strobe(8'hAA);
        check_head("mr.pre", 2'b01, 8'hAA, 1'b1, 1'b0);
        nreset = 1'b0;
        #1;
        check_head("mr.async", 2'b00, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        tick();
        check_eq("mr.empty", 32'(u_if.imux_valid_o), 32'd0);
        strobe(8'h00);
        strobe(8'h01);
        strobe(8'h55);
        check_head("mr.55", 2'b01, 8'h55, 1'b1, 1'b1);
        u_if.imux_ready_i = 2'b01;
        tick();
        check_eq("mr.drained", 32'(u_if.imux_valid_o), 32'd0);

`ifdef IN_DEMUX_TIMEOUT_EN
        // Truncated frame abandoned after 16 idle clocks
        u_if.imux_ready_i = 2'b01;
        strobe(8'h00);
        strobe(8'h04);
        strobe(8'hAA);
        check_head("to.aa", 2'b01, 8'hAA, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) tick();
        check_eq("to.drained", 32'(u_if.imux_valid_o), 32'd0);
        u_if.imux_ready_i = 2'b00;
        strobe(8'h01);
        strobe(8'h01);
        strobe(8'h99);
        check_head("to.99", 2'b10, 8'h99, 1'b1, 1'b1);
        u_if.imux_ready_i = 2'b10;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/in_demux.md
IN_DEMUX -- requirements
Module: in_demux

Interface
REQ-001 Parameter N_SINKS, default 2: number of downstream byte sinks, 1..8.
REQ-002 Parameter FIFO_DEPTH, default 8: buffered payload entries, power of two, at least 2.
REQ-003 Parameter TIMEOUT, default 1024: idle-clock limit inside a frame; used only when IN_DEMUX_TIMEOUT_EN is defined.
REQ-004 clk_i  in  1  single system clock; all logic on its rising edge.
REQ-005 nreset_i  in  1  asynchronous, active-low reset.
REQ-006 in_data_i  in  8  byte received from the host.
REQ-007 in_rdy_i  in  1  one-cycle strobe marking in_data_i valid; there is no backpressure toward the host.
REQ-008 imux_data_o  out  8  payload byte at the FIFO head.
REQ-009 imux_valid_o  out  N_SINKS  one-hot valid for the destination sink; zero when the FIFO is empty.
REQ-010 imux_ready_i  in  N_SINKS  per-sink accept; a byte transfers when valid[k] and ready[k] are both high on the same edge.
REQ-011 imux_sof_o / imux_eof_o  out  1 each  head byte is the first / last payload byte of its frame.
REQ-012 overflow_o  out  1  sticky flag: a payload byte was dropped because the FIFO was full.
REQ-013 bad_dest_o  out  1  one-cycle pulse when a header names a destination >= N_SINKS.
REQ-014 overflow_clr_i  in  1  synchronous clear of overflow_o.

Function
REQ-015 Frame format: byte 0 = destination id; byte 1 = payload length L, where L = 0 means 256; then L payload bytes.
REQ-016 Parser FSM states:
  - DEST: latch dest on strobe, go to LEN.
  - LEN: latch count; go to PAYLOAD if dest is valid, otherwise go to DISCARD and pulse bad_dest_o.
  - PAYLOAD: push each payload byte.
  - DISCARD: consume L bytes without pushing.
REQ-017 From PAYLOAD or DISCARD, the FSM returns to DEST on the strobe of the L-th payload byte.
REQ-018 The payload counter is 9 bits wide and loaded with L (256 when L = 0); it decrements per payload byte and never wraps.
REQ-019 Each FIFO entry is {data, dest, sof, eof}: sof is set on payload byte 1 and eof on byte L (both set when L = 1).
REQ-020 Latency into an empty FIFO: a byte strobed on edge n is presented with valid on the output by edge n+1.
REQ-021 Head stability: data, valid, sof and eof are held stable until the byte is accepted.
REQ-022 Only the head's destination valid bit may be high.
REQ-023 Full FIFO: a push is refused when the registered occupancy equals FIFO_DEPTH, even if a pop happens in the same cycle.
REQ-024 A refused byte is dropped, still decrements the counter, and sets overflow_o.
REQ-025 Empty FIFO with push and pop in the same cycle: not possible, because valid is low while empty.
REQ-026 Non-full FIFO with push and pop in the same cycle: both succeed and occupancy is unchanged.
REQ-027 If overflow_clr_i and a new overflow occur in the same cycle, overflow_o is set (set wins).
REQ-028 Read and write pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.

Reset
REQ-029 While nreset_i is low, and on its assertion: FSM = DEST, counter = 0, FIFO emptied, imux_valid_o = 0, imux_data_o = 0, sof/eof = 0, overflow_o = 0, bad_dest_o = 0.
REQ-030 Reset asserted mid-frame discards any partial frame; the first strobe after deassertion is parsed as a destination byte.

Configuration
REQ-031 With IN_DEMUX_TIMEOUT_EN defined, an idle counter runs in LEN, PAYLOAD and DISCARD and clears on every strobe.
REQ-032 On reaching TIMEOUT idle clocks, the FSM returns to DEST.
REQ-033 Bytes already queued are unaffected by a timeout; the truncated frame's eof is never produced.
REQ-034 Without IN_DEMUX_TIMEOUT_EN, no idle counter exists and the FSM waits indefinitely.

Structure
REQ-035 Package host_pkg holds:
  - frame field offsets;
  - the FIFO entry typedef;
  - the LEN_ZERO_MEANS = 256 constant;
  - the FSM state encoding shared with reg_manager framing.
REQ-036 The FIFO is the sub-module byte_fifo, parameterised by width and depth, with registered full/empty flags.

Verification
REQ-037 Frame 00 03 AA BB CC with sink 0 always ready -> sink 0 receives AA (sof), BB, CC (eof) on three consecutive cycles, each one cycle after its strobe.
REQ-038 Frame 05 02 11 22 with N_SINKS = 2 -> bad_dest_o pulses once, no valid is asserted, and the next frame 01 01 77 delivers 77 to sink 1 with sof = eof = 1.
REQ-039 Sink 0 ready held low, frame 00 0A plus 10 bytes, FIFO_DEPTH = 8 -> 8 bytes queued, overflow_o = 1, FSM back in DEST; raising ready delivers the 8 bytes in order, none with eof.
REQ-040 Frame 01 00 followed by 256 bytes -> sink 1 receives 256 bytes, eof on the 256th, and the parser returns to DEST.
REQ-041 nreset_i pulsed low after 00 04 AA -> valid drops immediately, the FIFO is empty, and a following 00 01 55 delivers 55.
REQ-042 With IN_DEMUX_TIMEOUT_EN and TIMEOUT = 16: send 00 04 AA, idle 16 clocks, send 01 01 99 -> 99 is delivered to sink 1 with sof = eof = 1.
